// File: rtl/ip2_scan_out_capture.sv
// ip2 scan-chain receive side: strobed scan_out capture with 32-bit word readback.
// Optional macro IP2_SCAN_OUT_COMPARE_EN adds a saturating exp_bit mismatch counter.
module ip2_scan_out_capture #(
   parameter int DEPTH = 1536,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          reset_not,
   input  logic          enable,
   input  logic [5:0]    clk_counter,
   input  logic [5:0]    sample_phase,
   input  logic          start_re,
   input  logic [10:0]   skip_cnt,
   input  logic [10:0]   bit_cnt_max,
   input  logic          scan_out,
   input  logic          exp_bit,
   input  logic [AW-1:0] rd_addr,
   output logic [31:0]   rd_data,
   output logic [1:0]    state,
   output logic          status_busy,
   output logic          status_done,
   output logic [10:0]   bit_cnt,
   output logic [10:0]   err_cnt
);

   localparam int          NW       = DEPTH / 32;
   localparam logic [10:0] LAST_MAX = 11'(DEPTH - 1);
   localparam logic [10:0] CNT_MAX  = 11'(DEPTH);
   localparam logic [AW:0] NW_W     = NW[AW:0];

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      SKIP    = 2'b01,
      CAPTURE = 2'b10,
      DONE    = 2'b11
   } state_t;

   state_t st;
   state_t st_nx;

   logic             strobe;
   logic [10:0]      last_idx;
   logic             last_hit;
   logic [10:0]      skip_q;
   logic [10:0]      skip_nx;
   logic [DEPTH-1:0] data;
   logic [31:0]      rd_word;
   logic             clr;
   logic             skip_inc;
   logic             store;
   logic             set_done;

   assign state    = st;
   assign strobe   = (clk_counter == sample_phase);
   assign skip_nx  = skip_q + 11'd1;
   assign last_idx = (bit_cnt_max > LAST_MAX) ? LAST_MAX : bit_cnt_max;

   // The DEPTH-1 stop keeps bit_cnt and the write index in range
   // even if bit_cnt_max is lowered below bit_cnt mid-capture.
   assign last_hit = (bit_cnt == last_idx) || (bit_cnt == LAST_MAX);

   assign rd_word = ({1'b0, rd_addr} < NW_W) ?
                    data[{rd_addr, 5'b0} +: 32] : 32'h0;

   always_ff @(posedge clk) begin
      if (!reset_not) begin
         st <= IDLE;
      end else begin
         st <= st_nx;
      end
   end

   always_comb begin
      st_nx    = st;
      clr      = 1'b0;
      skip_inc = 1'b0;
      store    = 1'b0;
      set_done = 1'b0;
      if (!enable) begin
         st_nx = IDLE;
      end else begin
         unique case (st)
            IDLE: begin
               if (start_re) begin
                  clr   = 1'b1;
                  st_nx = SKIP;
               end
            end
            SKIP: begin
               if (start_re) begin
                  clr   = 1'b1;
                  st_nx = SKIP;
               end else if (skip_cnt == 11'd0) begin
                  st_nx = CAPTURE;
               end else if (strobe) begin
                  skip_inc = 1'b1;
                  if (skip_nx == skip_cnt) begin
                     st_nx = CAPTURE;
                  end
               end
            end
            CAPTURE: begin
               if (start_re) begin
                  clr   = 1'b1;
                  st_nx = SKIP;
               end else if (strobe) begin
                  store = 1'b1;
                  if (last_hit) begin
                     st_nx = DONE;
                  end
               end
            end
            DONE: begin
               set_done = 1'b1;
               st_nx    = IDLE;
            end
            default: begin
               st_nx = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_not) begin
         skip_q      <= '0;
         bit_cnt     <= '0;
         status_done <= 1'b0;
         status_busy <= 1'b0;
         rd_data     <= '0;
         data        <= '0;
      end else begin
         status_busy <= (st == SKIP) || (st == CAPTURE);
         rd_data     <= rd_word;
         if (clr) begin
            skip_q      <= '0;
            bit_cnt     <= '0;
            status_done <= 1'b0;
         end else begin
            if (skip_inc) begin
               skip_q <= skip_nx;
            end
            if (store) begin
               data[bit_cnt] <= scan_out;
               if (bit_cnt != CNT_MAX) begin
                  bit_cnt <= bit_cnt + 11'd1;
               end
            end
            if (set_done) begin
               status_done <= 1'b1;
            end
         end
      end
   end

`ifdef IP2_SCAN_OUT_COMPARE_EN
   always_ff @(posedge clk) begin
      if (!reset_not) begin
         err_cnt <= '0;
      end else if (clr) begin
         err_cnt <= '0;
      end else if (store && (scan_out != exp_bit) &&
                   (err_cnt != 11'h7FF)) begin
         err_cnt <= err_cnt + 11'd1;
      end
   end
`else
   logic unused_exp;
   assign unused_exp = exp_bit;
   assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_ip2_scan_out_capture.sv
// Randomized bench for ip2_scan_out_capture with a cycle-level reference model.
module tb_ip2_scan_out_capture;

   localparam int DEPTH = 1536;
   localparam int NW    = DEPTH / 32;
`ifdef IP2_SCAN_OUT_COMPARE_EN
   localparam bit CMP = 1'b1;
`else
   localparam bit CMP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_not = 1'b0;
   logic        enable = 1'b1;
   logic [5:0]  cc = 6'd0;
   logic [5:0]  sample_phase = 6'd1;
   logic        start_re = 1'b0;
   logic [10:0] skip_cnt = 11'd0;
   logic [10:0] bit_cnt_max = 11'd31;
   logic        scan_out = 1'b0;
   logic        exp_bit = 1'b0;
   logic [5:0]  rd_addr = 6'd0;
   logic [31:0] rd_data;
   logic [1:0]  state;
   logic        status_busy;
   logic        status_done;
   logic [10:0] bit_cnt;
   logic [10:0] err_cnt;

   ip2_scan_out_capture #(.DEPTH(DEPTH), .AW(6)) dut (
      .clk(clk), .reset_not(reset_not), .enable(enable),
      .clk_counter(cc), .sample_phase(sample_phase),
      .start_re(start_re), .skip_cnt(skip_cnt),
      .bit_cnt_max(bit_cnt_max), .scan_out(scan_out),
      .exp_bit(exp_bit), .rd_addr(rd_addr), .rd_data(rd_data),
      .state(state), .status_busy(status_busy),
      .status_done(status_done), .bit_cnt(bit_cnt),
      .err_cnt(err_cnt)
   );

   initial forever #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   bit chk_on = 1'b0;

   int per = 4;
   bit fill_rand = 1'b0;
   bit fill_bit = 1'b0;
   bit exp_rand = 1'b0;
   bit rnd_rd = 1'b1;
   bit stage[$];
   bit pq[$];

   int          m_phase = 0;
   int          m_cnt = 0;
   int          m_skip = 0;
   int          m_err = 0;
   bit          m_done = 1'b0;
   bit          m_busy = 1'b0;
   logic [31:0] m_rd = 32'h0;
   bit          mem[DEPTH];

   task automatic cmp(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: spec rules evaluated once per clk on the sampled inputs.
   initial begin : model
      int last;
      logic [31:0] w;
      bit stb;
      forever begin
         @(posedge clk);
         stb = (cc == sample_phase);
         w = 32'h0;
         if (int'(rd_addr) < NW)
            for (int k = 0; k < 32; k++) w[k] = mem[32 * int'(rd_addr) + k];
         if (!reset_not) begin
            m_phase = 0; m_cnt = 0; m_skip = 0; m_err = 0;
            m_done = 0; m_busy = 0; m_rd = 32'h0;
            for (int k = 0; k < DEPTH; k++) mem[k] = 1'b0;
         end else begin
            m_rd = w;
            m_busy = (m_phase == 1) || (m_phase == 2);
            if (!enable) begin
               m_phase = 0;
            end else if (m_phase == 3) begin
               m_done = 1'b1;
               m_phase = 0;
            end else if (start_re) begin
               m_cnt = 0; m_skip = 0; m_err = 0; m_done = 0;
               m_phase = 1;
            end else if (m_phase == 1) begin
               if (skip_cnt == 0) begin
                  m_phase = 2;
               end else if (stb) begin
                  m_skip = (m_skip + 1) % 2048;
                  if (m_skip == int'(skip_cnt)) m_phase = 2;
               end
            end else if (m_phase == 2 && stb) begin
               last = (int'(bit_cnt_max) > DEPTH - 1) ? DEPTH - 1
                                                    : int'(bit_cnt_max);
               mem[m_cnt] = scan_out;
               if (CMP && scan_out != exp_bit && m_err < 2047) m_err++;
               if (m_cnt == last) m_phase = 3;
               if (m_cnt < DEPTH) m_cnt++;
            end
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk);
         if (chk_on) begin
            cmp("state", 32'(state), 32'(m_phase));
            cmp("busy", 32'(status_busy), 32'(m_busy));
            cmp("done", 32'(status_done), 32'(m_done));
            cmp("bit_cnt", 32'(bit_cnt), 32'(m_cnt));
            cmp("err_cnt", 32'(err_cnt), 32'(m_err));
            cmp("rd_data", rd_data, m_rd);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      start_re = 1'b0;
      cc = 6'((int'(cc) + 1) % per);
      if (cc == sample_phase) begin
         if (pq.size() > 0) scan_out = pq.pop_front();
         else if (fill_rand) scan_out = 1'($urandom_range(0, 1));
         else scan_out = fill_bit;
         exp_bit = exp_rand ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (rnd_rd) rd_addr = 6'($urandom_range(0, 63));
   endtask

   task automatic launch(input int sk, input int mx);
      skip_cnt = 11'(sk);
      bit_cnt_max = 11'(mx);
      do tick(); while (int'(cc) != (int'(sample_phase) + 1) % per);
      pq = stage;
      stage.delete();
      start_re = 1'b1;
   endtask

   task automatic finish_run(input int budget);
      int n = 0;
      tick();
      while (m_phase != 0 && n < budget) begin
         tick();
         n++;
      end
      if (m_phase != 0) begin
         checks++; failures++;
         $display("FAIL run_timeout: still busy after %0d cycles", n);
      end
   endtask

   task automatic wait_count(input int target, input int budget);
      int n = 0;
      while (m_cnt != target && n < budget) begin
         tick();
         n++;
      end
      if (m_cnt != target) begin
         checks++; failures++;
         $display("FAIL wait_count: got %0d want %0d", m_cnt, target);
      end
   endtask

   task automatic rd_check(input string nm, input int a,
                           input logic [31:0] exp);
      rd_addr = 6'(a);
      tick();
      cmp(nm, rd_data, exp);
   endtask

   initial begin : main
      int n;
      tick();
      chk_on = 1'b1;
      cmp("rst_state", 32'(state), 32'h0);
      cmp("rst_busy", 32'(status_busy), 32'h0);
      cmp("rst_bitcnt", 32'(bit_cnt), 32'h0);
      cmp("rst_rd", rd_data, 32'h0);
      reset_not = 1'b1;

      // Short capture over a word of ones.
      rnd_rd = 1'b0;
      fill_bit = 1'b1;
      launch(0, 31);
      finish_run(1000);
      fill_bit = 1'b0;
      launch(0, 7);
      finish_run(1000);
      rd_check("short_word0", 0, 32'hFFFFFF00);
      cmp("short_bitcnt", 32'(bit_cnt), 32'd8);
      cmp("short_done", 32'(status_done), 32'h1);

      // Skip latency.
      stage = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      launch(3, 31);
      finish_run(1000);
      rd_check("skip_word0", 0, 32'h00000002);

      // Full-depth alternating capture.
      per = 8;
      sample_phase = 6'd5;
      for (int i = 0; i < DEPTH; i++) stage.push_back(i % 2 == 0);
      launch(0, 1535);
      finish_run(20000);
      cmp("basic_done", 32'(status_done), 32'h1);
      cmp("basic_bitcnt", 32'(bit_cnt), 32'd1536);
      for (int a = 0; a < NW; a++) rd_check("basic_word", a, 32'h55555555);
      rd_check("rd_oob48", 48, 32'h0);
      rd_check("rd_oob63", 63, 32'h0);

      // Restart and enable drop.
      per = 4;
      sample_phase = 6'd2;
      fill_rand = 1'b1;
      rnd_rd = 1'b1;
      launch(2, 1535);
      wait_count(100, 2000);
      start_re = 1'b1;
      tick();
      cmp("restart_state", 32'(state), 32'h1);
      cmp("restart_bitcnt", 32'(bit_cnt), 32'h0);
      cmp("restart_done", 32'(status_done), 32'h0);
      cmp("restart_busy", 32'(status_busy), 32'h1);
      wait_count(50, 2000);
      enable = 1'b0;
      tick();
      enable = 1'b1;
      cmp("disable_state", 32'(state), 32'h0);
      cmp("disable_bitcnt", 32'(bit_cnt), 32'd50);

      // Reset mid-capture.
      launch(0, 1535);
      wait_count(20, 2000);
      reset_not = 1'b0;
      tick();
      reset_not = 1'b1;
      cmp("mrst_state", 32'(state), 32'h0);
      cmp("mrst_busy", 32'(status_busy), 32'h0);
      cmp("mrst_done", 32'(status_done), 32'h0);
      cmp("mrst_bitcnt", 32'(bit_cnt), 32'h0);
      cmp("mrst_err", 32'(err_cnt), 32'h0);
      cmp("mrst_rd", rd_data, 32'h0);

      // Mismatch counting.
      fill_rand = 1'b0;
      fill_bit = 1'b0;
      for (int i = 0; i < 64; i++) stage.push_back(i == 10 || i == 20);
      launch(0, 63);
      finish_run(1000);
      cmp("cmp_err_done", 32'(err_cnt), CMP ? 32'd2 : 32'd0);
      launch(0, 63);
      tick();
      cmp("cmp_err_clear", 32'(err_cnt), 32'h0);
      finish_run(1000);

      // Randomized runs with restarts, enable drops and clamped lengths.
      fill_rand = 1'b1;
      exp_rand = 1'b1;
      for (int r = 0; r < 30; r++) begin
         per = (r == 7) ? 4 : $urandom_range(2, 8);
         sample_phase = 6'($urandom_range(0, per - 1));
         skip_cnt = 11'($urandom_range(0, 4));
         bit_cnt_max = (r == 7) ? 11'd2000 : 11'($urandom_range(0, 80));
         repeat ($urandom_range(0, 5)) tick();
         start_re = 1'b1;
         n = 0;
         tick();
         while (m_phase != 0 && n < 30000) begin
            tick();
            n++;
            if (r != 7 && $urandom_range(0, 299) == 0) start_re = 1'b1;
            enable = (r != 7 && $urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
         end
         enable = 1'b1;
         if (m_phase != 0) begin
            checks++; failures++;
            $display("FAIL rand_timeout: run %0d phase %0d", r, m_phase);
         end
         if (r == 7) cmp("clamp_bitcnt", 32'(bit_cnt), 32'd1536);
      end
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
